// File: rtl/flex_counter_ud_if.sv
// Control and status bundle for flex_counter_ud. The master drives the controls
// and the slave (the counter) returns count and flags.
interface flex_counter_ud_if #(
    parameter int NUM_CNT_BITS = 4
);
    logic                    clear;
    logic                    load;
    logic [NUM_CNT_BITS-1:0] load_val;
    logic                    count_enable;
    logic                    count_up;
    logic                    one_shot;
    logic [NUM_CNT_BITS-1:0] rollover_val;
    logic [NUM_CNT_BITS-1:0] count_out;
    logic                    rollover_flag;
    logic                    wrap_pulse;
    logic                    done_flag;

    modport master (
        output clear, load, load_val, count_enable, count_up, one_shot, rollover_val,
        input  count_out, rollover_flag, wrap_pulse, done_flag
    );

    modport slave (
        input  clear, load, load_val, count_enable, count_up, one_shot, rollover_val,
        output count_out, rollover_flag, wrap_pulse, done_flag
    );
endinterface

// File: rtl/flex_counter_ud.sv
// Parametrised up/down counter with programmable rollover value, parallel load,
// wrap or one-shot (saturating) mode and registered status flags.
module flex_counter_ud #(
    parameter int NUM_CNT_BITS = 4
) (
    input logic              clk,
    input logic              n_rst,
    flex_counter_ud_if.slave bus
);
    localparam logic [NUM_CNT_BITS-1:0] ZERO = '0;
    localparam logic [NUM_CNT_BITS-1:0] ONE  = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

    logic [NUM_CNT_BITS-1:0] count_q, count_d;
    logic                    roll_q, roll_d;
    logic                    wrap_q, wrap_d;
    logic                    done_q, done_d;
    logic [NUM_CNT_BITS-1:0] terminal;
    logic                    rangeValid;

    assign rangeValid = (bus.rollover_val != ZERO);
    assign terminal   = bus.count_up ? bus.rollover_val : ONE;

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        done_d  = done_q;

        if (bus.clear) begin
            count_d = ZERO;
            done_d  = 1'b0;
        end else if (bus.load) begin
            count_d = bus.load_val;
            done_d  = 1'b0;
        end else if (bus.count_enable && rangeValid) begin
            if (bus.count_up) begin
                if (count_q >= bus.rollover_val) begin
                    if (!bus.one_shot) begin
                        count_d = ONE;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q + ONE;
                end
            end else begin
                // Zero sits outside the 1..rollover_val range, so it re-enters at the top silently.
                if (count_q == ZERO) begin
                    count_d = bus.rollover_val;
                end else if (count_q == ONE) begin
                    if (!bus.one_shot) begin
                        count_d = bus.rollover_val;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q - ONE;
                end
            end

            if (bus.one_shot && (count_d == terminal)) begin
                done_d = 1'b1;
            end
        end

        roll_d = rangeValid && (count_d == bus.rollover_val);
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count_q <= ZERO;
            roll_q  <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            roll_q  <= roll_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign bus.count_out     = count_q;
    assign bus.rollover_flag = roll_q;
    assign bus.wrap_pulse    = wrap_q;
    assign bus.done_flag     = done_q;
endmodule

// File: tb/tb_flex_counter_ud.sv
// Directed scoreboard bench for flex_counter_ud: a 4-bit and an 8-bit instance
// share clock and reset; each step queues its expected outputs and checks them after the edge.
module tb_flex_counter_ud;
    typedef struct {
        int         sel;
        logic [7:0] cnt;
        logic       roll;
        logic       wrap;
        logic       done;
        string      tag;
    } expect_t;

    logic    clk = 1'b0;
    logic    n_rst = 1'b0;
    expect_t sbQueue[$];
    int      compared = 0;
    int      mismatched = 0;

    flex_counter_ud_if #(.NUM_CNT_BITS(4)) bus4 ();
    flex_counter_ud_if #(.NUM_CNT_BITS(8)) bus8 ();

    flex_counter_ud #(.NUM_CNT_BITS(4)) dut4 (.clk(clk), .n_rst(n_rst), .bus(bus4.slave));
    flex_counter_ud #(.NUM_CNT_BITS(8)) dut8 (.clk(clk), .n_rst(n_rst), .bus(bus8.slave));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input int sel, input logic clr, input logic ld,
                                 input logic [7:0] lv, input logic en, input logic up,
                                 input logic os, input logic [7:0] rv,
                                 input logic [7:0] eCnt, input logic eRoll,
                                 input logic eWrap, input logic eDone, input string tag);
        expect_t e;
        @(negedge clk);
        if (sel == 0) begin
            bus4.clear = clr; bus4.load = ld; bus4.load_val = lv[3:0];
            bus4.count_enable = en; bus4.count_up = up; bus4.one_shot = os;
            bus4.rollover_val = rv[3:0];
        end else begin
            bus8.clear = clr; bus8.load = ld; bus8.load_val = lv;
            bus8.count_enable = en; bus8.count_up = up; bus8.one_shot = os;
            bus8.rollover_val = rv;
        end
        e.sel = sel; e.cnt = eCnt; e.roll = eRoll; e.wrap = eWrap; e.done = eDone; e.tag = tag;
        sbQueue.push_back(e);
        checkOutput();
    endtask

    task automatic checkOutput();
        expect_t    e;
        logic [7:0] oCnt;
        logic       oRoll, oWrap, oDone;
        @(posedge clk);
        #1;
        e = sbQueue.pop_front();
        if (e.sel == 0) begin
            oCnt = {4'b0000, bus4.count_out};
            oRoll = bus4.rollover_flag; oWrap = bus4.wrap_pulse; oDone = bus4.done_flag;
        end else begin
            oCnt = bus8.count_out;
            oRoll = bus8.rollover_flag; oWrap = bus8.wrap_pulse; oDone = bus8.done_flag;
        end
        compared++;
        assert (oCnt === e.cnt) else begin
            mismatched++;
            $error("[TB] FAIL %s count_out: observed %0d expected %0d", e.tag, oCnt, e.cnt);
        end
        compared++;
        assert (oRoll === e.roll) else begin
            mismatched++;
            $error("[TB] FAIL %s rollover_flag: observed %b expected %b", e.tag, oRoll, e.roll);
        end
        compared++;
        assert (oWrap === e.wrap) else begin
            mismatched++;
            $error("[TB] FAIL %s wrap_pulse: observed %b expected %b", e.tag, oWrap, e.wrap);
        end
        compared++;
        assert (oDone === e.done) else begin
            mismatched++;
            $error("[TB] FAIL %s done_flag: observed %b expected %b", e.tag, oDone, e.done);
        end
    endtask

    initial begin
        bus4.clear = 0; bus4.load = 0; bus4.load_val = 0; bus4.count_enable = 0;
        bus4.count_up = 0; bus4.one_shot = 0; bus4.rollover_val = 0;
        bus8.clear = 0; bus8.load = 0; bus8.load_val = 0; bus8.count_enable = 0;
        bus8.count_up = 0; bus8.one_shot = 0; bus8.rollover_val = 0;

        // Reset held two edges while enabled, then released with no step.
        n_rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 9, 0, 0, 0, 0, "reset1");
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 9, 0, 0, 0, 0, "reset2");
        applyStimulus(1, 0, 0, 0, 1, 1, 0, 9, 0, 0, 0, 0, "reset8");
        n_rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 9, 0, 0, 0, 0, "postReset");

        // Up wrap with rollover_val = 9.
        for (int i = 1; i <= 9; i++)
            applyStimulus(0, 0, 0, 0, 1, 1, 0, 9, 8'(i), (i == 9), 0, 0, $sformatf("up%0d", i));
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 9, 1, 0, 1, 0, "upWrap");
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 9, 1, 0, 0, 0, "upWrapHold");

        // Down wrap with rollover_val = 5 from a load of 3, then down from zero.
        applyStimulus(0, 0, 1, 3, 0, 0, 0, 5, 3, 0, 0, 0, "dnLoad");
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 5, 2, 0, 0, 0, "dn2");
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 5, 1, 0, 0, 0, "dn1");
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 5, 5, 1, 1, 0, "dnWrap");
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 5, 4, 0, 0, 0, "dn4");
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, "dnClear");
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 5, 5, 1, 0, 0, "dnFromZero");

        // One-shot up to 4, saturate, then clear.
        applyStimulus(0, 1, 0, 0, 0, 1, 1, 4, 0, 0, 0, 0, "osClear0");
        for (int i = 1; i <= 4; i++)
            applyStimulus(0, 0, 0, 0, 1, 1, 1, 4, 8'(i), (i == 4), 0, (i == 4), $sformatf("os%0d", i));
        applyStimulus(0, 0, 0, 0, 1, 1, 1, 4, 4, 1, 0, 1, "osSat1");
        applyStimulus(0, 0, 0, 0, 1, 1, 1, 4, 4, 1, 0, 1, "osSat2");
        applyStimulus(0, 1, 0, 0, 0, 1, 1, 4, 0, 0, 0, 0, "osClear");

        // One-shot down; done survives one_shot deassertion, load clears it.
        applyStimulus(0, 0, 1, 3, 0, 0, 1, 5, 3, 0, 0, 0, "osDnLoad");
        applyStimulus(0, 0, 0, 0, 1, 0, 1, 5, 2, 0, 0, 0, "osDn2");
        applyStimulus(0, 0, 0, 0, 1, 0, 1, 5, 1, 0, 0, 1, "osDn1");
        applyStimulus(0, 0, 0, 0, 1, 0, 1, 5, 1, 0, 0, 1, "osDnSat");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 1, "doneSticky");
        applyStimulus(0, 0, 1, 2, 0, 0, 0, 5, 2, 0, 0, 0, "doneLoadClr");

        // Priority: clear beats load and enable; load beats enable, no clamping.
        applyStimulus(0, 1, 1, 7, 1, 1, 0, 9, 0, 0, 0, 0, "prioClear");
        applyStimulus(0, 0, 1, 15, 1, 1, 0, 9, 15, 0, 0, 0, "prioLoad");
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 9, 1, 0, 1, 0, "aboveWrap");

        // rollover_val = 0 disables stepping in both directions.
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, "rv0Up");
        applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, "rv0Dn");

        // rollover_val = 1: back-to-back wraps keep the pulse high.
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 1, 1, 1, 1, 0, "rv1Wrap1");
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 1, 1, 1, 1, 0, "rv1Wrap2");
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0, 0, "rv1Hold");

        // 8-bit instance counting to 255 and wrapping to 1.
        applyStimulus(1, 0, 1, 250, 0, 1, 0, 255, 250, 0, 0, 0, "n8Load");
        for (int i = 251; i <= 255; i++)
            applyStimulus(1, 0, 0, 0, 1, 1, 0, 255, 8'(i), (i == 255), 0, 0, $sformatf("n8Up%0d", i));
        applyStimulus(1, 0, 0, 0, 1, 1, 0, 255, 1, 0, 1, 0, "n8Wrap");

        // Reset mid-count wins over load and enable.
        applyStimulus(0, 0, 1, 5, 0, 1, 0, 9, 5, 0, 0, 0, "midLoad");
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 9, 6, 0, 0, 0, "midStep");
        n_rst = 1'b0;
        applyStimulus(0, 0, 1, 9, 1, 1, 0, 9, 0, 0, 0, 0, "midReset");
        n_rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 9, 1, 0, 0, 0, "postMidReset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
